// File: rtl/lcd_pkg.sv
// lcd_pkg: shared geometry defaults, capture FSM encoding and ERR bit positions
package lcd_pkg;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;
  typedef enum logic [1:0] {SYNC_SEARCH, WAIT_DEN, ACTIVE, LINE_GAP} state_t;
  localparam int ERR_W   = 0;
  localparam int ERR_H   = 1;
  localparam int ERR_DEN = 2;
endpackage

// File: rtl/lcd_edge_det.sv
// lcd_edge_det: flags a change of d against its previous PIX_CE sample, silent until one sample exists
module lcd_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic chg
);
  logic prev, seen;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      seen <= 1'b0;
    end else if (ce) begin
      prev <= d;
      seen <= 1'b1;
    end
  end
  assign chg = ce && seen && (d != prev);
endmodule

// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture: LCD receive path rebuilding pixel coordinates, writing the frame store,
// measuring line/frame geometry and publishing a per-frame checksum
module lcd_frame_capture
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PIX_CE,
  input  logic              HD,
  input  logic              VD,
  input  logic              DEN,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [23:0]       WR_DATA,
  output logic              FRAME_DONE,
  output logic [31:0]       FRAME_SUM,
  output logic [11:0]       MEAS_W,
  output logic [9:0]        MEAS_H,
  output logic [2:0]        ERR,
  output logic              LOCKED
);
  localparam logic [11:0]       HW = 12'(H_ACTIVE);
  localparam logic [9:0]        VH = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HA = ADDR_W'(H_ACTIVE);
  state_t state, state_n;
  logic hd_chg, vd_chg, den_chg, hd_fall, vd_fall, den_fall;
  logic pixel, line_end, frame_end, in_window, hd_seen, frame_err;
  logic [11:0] x;
  logic [9:0] y, y_fin;
  logic [ADDR_W-1:0] base;
  logic [31:0] sum;
  logic [2:0] err_set;
  lcd_edge_det u_hd (.clk(CLK), .rst(RST), .ce(PIX_CE), .d(HD), .chg(hd_chg));
  lcd_edge_det u_vd (.clk(CLK), .rst(RST), .ce(PIX_CE), .d(VD), .chg(vd_chg));
  lcd_edge_det u_den (.clk(CLK), .rst(RST), .ce(PIX_CE), .d(DEN), .chg(den_chg));
  assign hd_fall   = hd_chg && !HD;
  assign vd_fall   = vd_chg && !VD;
  assign den_fall  = den_chg && !DEN;
  assign in_window = x < HW && y < VH;
  assign y_fin     = line_end ? y + 10'd1 : y;
  always_ff @(posedge CLK) begin
    if (RST) state <= SYNC_SEARCH;
    else state <= state_n;
  end
  // A VD-falling sample is a sync event, never a pixel, even with DEN still high
  always_comb begin
    state_n   = state;
    pixel     = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    if (PIX_CE && state != SYNC_SEARCH) begin
      pixel     = DEN && !vd_fall;
      line_end  = state == ACTIVE && (vd_fall || den_fall);
      frame_end = vd_fall;
      state_n   = vd_fall ? WAIT_DEN : DEN ? ACTIVE : state == ACTIVE ? LINE_GAP : state;
    end else if (PIX_CE && vd_fall) begin
      state_n = WAIT_DEN;
    end
  end
  always_comb begin
    err_set          = 3'b000;
    err_set[ERR_W]   = line_end && x != HW;
    err_set[ERR_H]   = frame_end && y_fin != VH;
    err_set[ERR_DEN] = PIX_CE && LOCKED && DEN && !VD;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_SUM  <= '0;
      MEAS_W     <= '0;
      MEAS_H     <= '0;
      ERR        <= '0;
      LOCKED     <= 1'b0;
      x          <= '0;
      y          <= '0;
      base       <= '0;
      sum        <= '0;
      hd_seen    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      WR_EN      <= pixel && in_window;
      FRAME_DONE <= frame_end;
      ERR        <= ERR | err_set;
      hd_seen    <= frame_end ? hd_fall : hd_seen || hd_fall;
      frame_err  <= !frame_end && (frame_err || |err_set);
      LOCKED     <= frame_end ? !(frame_err || |err_set) && (hd_seen || hd_fall)
                              : LOCKED && !(|err_set);
      if (pixel) begin
        if (in_window) begin
          WR_ADDR <= base + ADDR_W'(x);
          WR_DATA <= {R, G, B};
        end
        x   <= (&x) ? x : x + 12'd1;
        sum <= sum + {8'h00, R, G, B};
      end
      if (line_end) begin
        MEAS_W <= x;
        x      <= '0;
        y      <= y + 10'd1;
        base   <= base + HA;
      end
      if (frame_end) begin
        MEAS_H    <= y_fin;
        FRAME_SUM <= sum;
        sum       <= '0;
        y         <= '0;
        base      <= '0;
      end
    end
  end
endmodule
